hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_muldiv_cnt.sv | 33 +++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard controller state encoding and multiply/divide defaults.
package pipeline_pkg;

  localparam int MULDIV_CYCLES_DEF = 32;
  localparam int CNT_W             = 6;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    MULDIV  = 2'd2,
    EXC     = 2'd3
  } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; the pipeline is the master, the controller the slave.
interface hazard_ctrl_if;

  logic       EX_MemRead;
  logic [4:0] EX_Rt;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       EX_MulDivStart;
  logic       ID_HiLoAccess;
  logic       M_MemReq;
  logic       M_MemReady;
  logic       M_Exception;

  logic       IF_Stall;
  logic       ID_Stall;
  logic       EX_Stall;
  logic       M_Stall;
  logic       IF_Flush;
  logic       ID_Flush;
  logic       EX_Flush;
  logic       PC_ExcSel;
  logic       MulDivBusy;

  modport master (
    output EX_MemRead, EX_Rt, ID_Rs, ID_Rt, EX_MulDivStart, ID_HiLoAccess,
           M_MemReq, M_MemReady, M_Exception,
    input  IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Flush, EX_Flush,
           PC_ExcSel, MulDivBusy
  );

  modport slave (
    input  EX_MemRead, EX_Rt, ID_Rs, ID_Rt, EX_MulDivStart, ID_HiLoAccess,
           M_MemReq, M_MemReady, M_Exception,
    output IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Flush, EX_Flush,
           PC_ExcSel, MulDivBusy
  );

endinterface

// File: rtl/hazard_muldiv_cnt.sv
// Multiply/divide occupancy down-counter: clear, load, hold and decrement with a terminal-count flag.
module hazard_muldiv_cnt
  import pipeline_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         hold,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !hold && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: exception flush, memory wait, HI/LO hazard and load-use stall.
// Define HAZARD_CTRL_MULDIV_EN to build the multiply/divide occupancy tracking.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
  input  logic         CLK,
  input  logic         RST_N,
  hazard_ctrl_if.slave hz
);

  hazard_state_t state, state_nxt;

  logic exc, mem_stall, load_use, hilo_haz, start_ok, cnt_zero, in_muldiv;
  logic if_stall, id_stall, ex_stall, m_stall;
  logic if_flush, id_flush, ex_flush, pc_exc_sel, busy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= RUN;
    else        state <= state_nxt;
  end

  assign exc      = hz.M_Exception;
  assign load_use = hz.EX_MemRead && (hz.EX_Rt != 5'd0) &&
                    ((hz.EX_Rt == hz.ID_Rs) || (hz.EX_Rt == hz.ID_Rt));

  // Once in MEMWAIT the stall is held by readiness alone, independent of the request line.
  always_comb begin
    mem_stall = 1'b0;
    unique case (state)
      MEMWAIT: mem_stall = !hz.M_MemReady;
      EXC:     mem_stall = 1'b0;
      default: mem_stall = hz.M_MemReq && !hz.M_MemReady;
    endcase
  end

`ifdef HAZARD_CTRL_MULDIV_EN
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULDIV_CYCLES - 1);

  assign in_muldiv = (state == MULDIV);
  assign hilo_haz  = in_muldiv && hz.ID_HiLoAccess;
  assign start_ok  = (state == RUN) && hz.EX_MulDivStart && !exc && !mem_stall;

  hazard_muldiv_cnt #(.W(CNT_W)) u_muldiv_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clear    (exc),
    .load     (start_ok),
    .load_val (LOAD_VAL),
    .en       (in_muldiv),
    .hold     (mem_stall),
    .zero     (cnt_zero)
  );
`else
  localparam int unsigned unused_cycles = MULDIV_CYCLES;
  logic unused_muldiv_inputs;

  assign unused_muldiv_inputs = hz.EX_MulDivStart ^ hz.ID_HiLoAccess;
  assign in_muldiv = 1'b0;
  assign hilo_haz  = 1'b0;
  assign start_ok  = 1'b0;
  assign cnt_zero  = 1'b1;
`endif

  always_comb begin
    state_nxt  = state;
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    ex_stall   = 1'b0;
    m_stall    = 1'b0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    ex_flush   = 1'b0;
    pc_exc_sel = 1'b0;
    busy       = 1'b0;

    if (exc) begin
      if_flush   = 1'b1;
      id_flush   = 1'b1;
      ex_flush   = 1'b1;
      pc_exc_sel = 1'b1;
      state_nxt  = EXC;
    end else if (state == EXC) begin
      if_flush  = 1'b1;
      state_nxt = RUN;
    end else begin
      if (mem_stall) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        ex_stall = 1'b1;
        m_stall  = 1'b1;
      end else if (hilo_haz || load_use) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        ex_flush = 1'b1;
      end
      busy = in_muldiv;

      unique case (state)
        RUN: begin
          if (mem_stall)     state_nxt = MEMWAIT;
          else if (start_ok) state_nxt = MULDIV;
        end
        MEMWAIT: if (hz.M_MemReady) state_nxt = RUN;
        // A memory stall during MULDIV freezes the counter rather than leaving the state.
        MULDIV:  if (cnt_zero && !mem_stall) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Outputs are forced low combinationally while reset is held.
  assign hz.IF_Stall   = RST_N & if_stall;
  assign hz.ID_Stall   = RST_N & id_stall;
  assign hz.EX_Stall   = RST_N & ex_stall;
  assign hz.M_Stall    = RST_N & m_stall;
  assign hz.IF_Flush   = RST_N & if_flush;
  assign hz.ID_Flush   = RST_N & id_flush;
  assign hz.EX_Flush   = RST_N & ex_flush;
  assign hz.PC_ExcSel  = RST_N & pc_exc_sel;
  assign hz.MulDivBusy = RST_N & busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; MulDiv checks follow HAZARD_CTRL_MULDIV_EN.
module tb_hazard_ctrl;
  import pipeline_pkg::*;

  // Output vector order: IF_Stall ID_Stall EX_Stall M_Stall IF_Flush ID_Flush EX_Flush PC_ExcSel MulDivBusy
  localparam logic [8:0] NONE    = 9'b000000000;
  localparam logic [8:0] LU      = 9'b110000100;
  localparam logic [8:0] MEM     = 9'b111100000;
  localparam logic [8:0] EXC_ALL = 9'b000011110;
  localparam logic [8:0] EXC1    = 9'b000010000;
  localparam logic [8:0] BUSY    = 9'b000000001;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MULDIV_CYCLES(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .hz    (hz)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running exp finished");
    $fatal(1, "timeout");
  end

  function automatic logic [8:0] outs();
    return {hz.IF_Stall, hz.ID_Stall, hz.EX_Stall, hz.M_Stall, hz.IF_Flush,
            hz.ID_Flush, hz.EX_Flush, hz.PC_ExcSel, hz.MulDivBusy};
  endfunction

  task automatic idle();
    hz.EX_MemRead = 1'b0; hz.EX_Rt = 5'd0; hz.ID_Rs = 5'd0; hz.ID_Rt = 5'd0;
    hz.EX_MulDivStart = 1'b0; hz.ID_HiLoAccess = 1'b0;
    hz.M_MemReq = 1'b0; hz.M_MemReady = 1'b0; hz.M_Exception = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    idle(); #2;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL reset_idle: got %b exp %b", outs(), NONE); end
    hz.EX_MemRead = 1'b1; hz.EX_Rt = 5'd5; hz.ID_Rs = 5'd5; hz.M_Exception = 1'b1;
    hz.M_MemReq = 1'b1; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL reset_gated: got %b exp %b", outs(), NONE); end
    n_chk++; if (dut.state !== RUN) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", dut.state, RUN); end
    idle(); tick(); RST_N = 1'b1; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL post_reset: got %b exp %b", outs(), NONE); end
    tick();
    n_chk++; if (dut.state !== RUN) begin n_fail++; $display("FAIL post_reset_state: got %0d exp %0d", dut.state, RUN); end
  endtask

  typedef struct {
    logic       mr;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [8:0] exp;
  } lu_vec_t;

  task automatic test_load_use();
    lu_vec_t tab[7];
    tab = '{'{1'b1, 5'd5,  5'd5,  5'd0,  LU},
            '{1'b1, 5'd0,  5'd5,  5'd0,  NONE},
            '{1'b1, 5'd0,  5'd0,  5'd0,  NONE},
            '{1'b1, 5'd7,  5'd3,  5'd7,  LU},
            '{1'b0, 5'd5,  5'd5,  5'd5,  NONE},
            '{1'b1, 5'd5,  5'd6,  5'd7,  NONE},
            '{1'b1, 5'd31, 5'd31, 5'd31, LU}};
    for (int i = 0; i < 7; i++) begin
      tick();
      hz.EX_MemRead = tab[i].mr; hz.EX_Rt = tab[i].ert; hz.ID_Rs = tab[i].rs; hz.ID_Rt = tab[i].rt;
      #1;
      n_chk++; if (outs() !== tab[i].exp) begin n_fail++; $display("FAIL load_use[%0d]: got %b exp %b", i, outs(), tab[i].exp); end
    end
    tick(); idle(); #1;
    n_chk++; if (dut.state !== RUN) begin n_fail++; $display("FAIL lu_no_state: got %0d exp %0d", dut.state, RUN); end
  endtask

  task automatic test_mem_wait();
    tick(); hz.M_MemReq = 1'b1; hz.M_MemReady = 1'b1; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL mem_ready_now: got %b exp %b", outs(), NONE); end
    tick();
    hz.M_MemReady = 1'b0; hz.EX_MemRead = 1'b1; hz.EX_Rt = 5'd9; hz.ID_Rt = 5'd9; #1;
    n_chk++; if (outs() !== MEM) begin n_fail++; $display("FAIL mem_prio: got %b exp %b", outs(), MEM); end
    hz.EX_MemRead = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++; if (outs() !== MEM) begin n_fail++; $display("FAIL mem_hold[%0d]: got %b exp %b", i, outs(), MEM); end
      n_chk++; if (dut.state !== MEMWAIT) begin n_fail++; $display("FAIL mem_state[%0d]: got %0d exp %0d", i, dut.state, MEMWAIT); end
    end
    tick(); hz.M_MemReady = 1'b1; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL mem_ready: got %b exp %b", outs(), NONE); end
    tick(); idle(); #1;
    n_chk++; if (dut.state !== RUN) begin n_fail++; $display("FAIL mem_return: got %0d exp %0d", dut.state, RUN); end
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL mem_after: got %b exp %b", outs(), NONE); end
  endtask

  task automatic test_muldiv();
    logic [8:0] exp;
`ifdef HAZARD_CTRL_MULDIV_EN
    tick(); hz.EX_MulDivStart = 1'b1; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL md_issue: got %b exp %b", outs(), NONE); end
    tick(); hz.EX_MulDivStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hz.ID_HiLoAccess = (i == 1); #1;
      exp = (i == 1) ? (BUSY | LU) : BUSY;
      n_chk++; if (outs() !== exp) begin n_fail++; $display("FAIL md_busy[%0d]: got %b exp %b", i, outs(), exp); end
      tick();
    end
    hz.ID_HiLoAccess = 1'b0; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL md_done: got %b exp %b", outs(), NONE); end
    hz.ID_HiLoAccess = 1'b1; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL hilo_run: got %b exp %b", outs(), NONE); end
    hz.ID_HiLoAccess = 1'b0; hz.EX_MulDivStart = 1'b1;
    tick(); hz.EX_MulDivStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hz.M_MemReq = (i == 1); hz.M_MemReady = 1'b0; #1;
      exp = (i == 1) ? (MEM | BUSY) : BUSY;
      n_chk++; if (outs() !== exp) begin n_fail++; $display("FAIL md_held[%0d]: got %b exp %b", i, outs(), exp); end
      tick();
    end
    hz.M_MemReq = 1'b0; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL md_held_done: got %b exp %b", outs(), NONE); end
`else
    tick(); hz.EX_MulDivStart = 1'b1; hz.ID_HiLoAccess = 1'b1; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL md_off_issue: got %b exp %b", outs(), NONE); end
    tick(); hz.EX_MulDivStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = NONE;
      n_chk++; if (outs() !== exp) begin n_fail++; $display("FAIL md_off[%0d]: got %b exp %b", i, outs(), exp); end
      tick();
    end
    hz.ID_HiLoAccess = 1'b0;
`endif
  endtask

  task automatic test_exception();
    tick(); hz.M_MemReq = 1'b1; hz.M_MemReady = 1'b0; #1;
    n_chk++; if (outs() !== MEM) begin n_fail++; $display("FAIL exc_pre_mem: got %b exp %b", outs(), MEM); end
    tick(); hz.M_Exception = 1'b1; #1;
    n_chk++; if (outs() !== EXC_ALL) begin n_fail++; $display("FAIL exc_memwait: got %b exp %b", outs(), EXC_ALL); end
    tick(); idle(); #1;
    n_chk++; if (outs() !== EXC1) begin n_fail++; $display("FAIL exc_one_mem: got %b exp %b", outs(), EXC1); end
    tick();
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL exc_clear_mem: got %b exp %b", outs(), NONE); end
    n_chk++; if (dut.state !== RUN) begin n_fail++; $display("FAIL exc_state_mem: got %0d exp %0d", dut.state, RUN); end
`ifdef HAZARD_CTRL_MULDIV_EN
    hz.EX_MulDivStart = 1'b1;
    tick(); hz.EX_MulDivStart = 1'b0; #1;
    n_chk++; if (outs() !== BUSY) begin n_fail++; $display("FAIL exc_pre_md: got %b exp %b", outs(), BUSY); end
    tick(); hz.M_Exception = 1'b1; #1;
    n_chk++; if (outs() !== EXC_ALL) begin n_fail++; $display("FAIL exc_muldiv: got %b exp %b", outs(), EXC_ALL); end
    tick(); hz.M_Exception = 1'b0; #1;
    n_chk++; if (outs() !== EXC1) begin n_fail++; $display("FAIL exc_one_md: got %b exp %b", outs(), EXC1); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL exc_clear_md[%0d]: got %b exp %b", i, outs(), NONE); end
    end
`endif
    tick();
    hz.M_Exception = 1'b1; hz.EX_MemRead = 1'b1; hz.EX_Rt = 5'd4; hz.ID_Rs = 5'd4;
    hz.M_MemReq = 1'b1; #1;
    n_chk++; if (outs() !== EXC_ALL) begin n_fail++; $display("FAIL exc_prio: got %b exp %b", outs(), EXC_ALL); end
    tick(); #1;
    n_chk++; if (outs() !== EXC_ALL) begin n_fail++; $display("FAIL exc_reenter: got %b exp %b", outs(), EXC_ALL); end
    tick(); idle(); #1;
    n_chk++; if (outs() !== EXC1) begin n_fail++; $display("FAIL exc_one_re: got %b exp %b", outs(), EXC1); end
    tick();
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL exc_clear_re: got %b exp %b", outs(), NONE); end
  endtask

  task automatic test_reset_mid();
`ifdef HAZARD_CTRL_MULDIV_EN
    tick(); hz.EX_MulDivStart = 1'b1;
    tick(); hz.EX_MulDivStart = 1'b0;
    tick();
    n_chk++; if (outs() !== BUSY) begin n_fail++; $display("FAIL rst_pre_md: got %b exp %b", outs(), BUSY); end
    RST_N = 1'b0; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL rst_muldiv: got %b exp %b", outs(), NONE); end
    n_chk++; if (dut.state !== RUN) begin n_fail++; $display("FAIL rst_md_state: got %0d exp %0d", dut.state, RUN); end
    tick(); RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL rst_md_after[%0d]: got %b exp %b", i, outs(), NONE); end
      tick();
    end
`endif
    tick(); hz.M_MemReq = 1'b1; hz.M_MemReady = 1'b0;
    tick();
    n_chk++; if (outs() !== MEM) begin n_fail++; $display("FAIL rst_pre_mem: got %b exp %b", outs(), MEM); end
    RST_N = 1'b0; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL rst_memwait: got %b exp %b", outs(), NONE); end
    idle(); tick(); RST_N = 1'b1; #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL rst_mem_after: got %b exp %b", outs(), NONE); end
    tick();
    n_chk++; if (dut.state !== RUN) begin n_fail++; $display("FAIL rst_mem_state: got %0d exp %0d", dut.state, RUN); end
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL rst_mem_idle: got %b exp %b", outs(), NONE); end
  endtask

  task automatic test_back_to_back();
    tick(); hz.EX_MemRead = 1'b1; hz.EX_Rt = 5'd12; hz.ID_Rs = 5'd12; #1;
    n_chk++; if (outs() !== LU) begin n_fail++; $display("FAIL b2b_lu: got %b exp %b", outs(), LU); end
    tick(); hz.EX_MemRead = 1'b0; hz.M_MemReq = 1'b1; hz.M_MemReady = 1'b0; #1;
    n_chk++; if (outs() !== MEM) begin n_fail++; $display("FAIL b2b_mem: got %b exp %b", outs(), MEM); end
    tick(); hz.M_MemReady = 1'b1; hz.EX_MemRead = 1'b1; #1;
    n_chk++; if (outs() !== LU) begin n_fail++; $display("FAIL b2b_ready_lu: got %b exp %b", outs(), LU); end
    tick(); idle(); #1;
    n_chk++; if (outs() !== NONE) begin n_fail++; $display("FAIL b2b_idle: got %b exp %b", outs(), NONE); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_muldiv();
    test_exception();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
